axi_sram: RTL

AXI responder that terminates the core's instruction-fetch and load/store master ports in simulation and FPGA bring-up builds. It serves INCR/FIXED read bursts (icache line refills) and single-beat reads/writes (LSU) from an internal word-addressed SRAM array. Read and write channels are fully independent state machines sharing one memory.

---
 rtl/axi_sram.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram.sv
// AXI responder backed by a word-addressed SRAM. The read and write channels run
// independent state machines over one shared array.
module axi_sram #(
   parameter logic [31:0] ADDR_BASE    = 32'h8000_0000,
   parameter int          DEPTH_WORDS  = 4096,
   parameter int          READ_LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_arvalid,
   output logic        o_arready,
   input  logic [31:0] i_araddr,
   input  logic [1:0]  i_arburst,
   input  logic [7:0]  i_arlen,
   input  logic [2:0]  i_arsize,
   output logic        o_rvalid,
   input  logic        i_rready,
   output logic [31:0] o_rdata,
   output logic [1:0]  o_rresp,
   output logic        o_rlast,
   input  logic        i_awvalid,
   output logic        o_awready,
   input  logic [31:0] i_awaddr,
   input  logic        i_wvalid,
   output logic        o_wready,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   output logic        o_bvalid,
   input  logic        i_bready,
   output logic [1:0]  o_bresp
);

   localparam int          IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  LAT_INIT = 4'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } r_state_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_t;

   function automatic logic f_in_range(input logic [31:0] a);
      return {1'b0, a - ADDR_BASE} < SPAN;
   endfunction

   function automatic logic [IDX_W-1:0] f_index(input logic [31:0] a);
      return IDX_W'((a - ADDR_BASE) >> 2);
   endfunction

   function automatic logic f_unsup(input logic [1:0] burst, input logic [2:0] size);
      return burst[1] || (size > 3'd2);
   endfunction

   logic [31:0] r_mem [DEPTH_WORDS];

   r_state_t    r_r_state;
   r_state_t    w_r_state_nxt;
   logic        r_arready;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;
   logic        r_rlast;
   logic [31:0] r_cur_addr;
   logic [7:0]  r_ar_len;
   logic        r_incr;
   logic        r_unsup;
   logic [7:0]  r_beat_cnt;
   logic [3:0]  r_lat_cnt;

   logic        w_ar_take;
   logic        w_load;
   logic [31:0] w_ld_addr;
   logic [7:0]  w_ld_cnt;
   logic [7:0]  w_ld_len;
   logic        w_ld_unsup;
   logic [31:0] w_ld_data;
   logic [1:0]  w_ld_resp;

   w_state_t    r_w_state;
   w_state_t    w_w_state_nxt;
   logic        r_awready;
   logic        r_wready;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic        r_aw_got;
   logic        r_wd_got;
   logic [31:0] r_aw_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;

   logic        w_aw_take;
   logic        w_wd_take;
   logic        w_aw_have;
   logic        w_wd_have;
   logic        w_commit;
   logic        w_b_done;
   logic [31:0] w_wr_addr;
   logic [31:0] w_wr_data;
   logic [3:0]  w_wr_strb;

   // Read FSM next state and beat-load selection
   always_comb begin
      w_r_state_nxt = r_r_state;
      w_ar_take     = 1'b0;
      w_load        = 1'b0;
      w_ld_addr     = r_cur_addr;
      w_ld_cnt      = r_beat_cnt;
      w_ld_len      = r_ar_len;
      w_ld_unsup    = r_unsup;
      case (r_r_state)
         R_IDLE: begin
            if (i_arvalid && r_arready) begin
               w_ar_take = 1'b1;
               if (READ_LATENCY == 1) begin
                  w_load        = 1'b1;
                  w_ld_addr     = i_araddr;
                  w_ld_cnt      = 8'd0;
                  w_ld_len      = i_arlen;
                  w_ld_unsup    = f_unsup(i_arburst, i_arsize);
                  w_r_state_nxt = R_DATA;
               end else begin
                  w_r_state_nxt = R_WAIT;
               end
            end else begin
               w_r_state_nxt = R_IDLE;
            end
         end
         R_WAIT: begin
            if (r_lat_cnt == 4'd0) begin
               w_load        = 1'b1;
               w_ld_cnt      = 8'd0;
               w_r_state_nxt = R_DATA;
            end else begin
               w_r_state_nxt = R_WAIT;
            end
         end
         R_DATA: begin
            if (i_rready) begin
               if (r_rlast) begin
                  w_r_state_nxt = R_IDLE;
               end else begin
                  w_load    = 1'b1;
                  w_ld_cnt  = r_beat_cnt + 8'd1;
                  w_ld_addr = r_incr ? (r_cur_addr + 32'd4) : r_cur_addr;
               end
            end else begin
               w_r_state_nxt = R_DATA;
            end
         end
         default: w_r_state_nxt = R_IDLE;
      endcase
   end

   // Beat contents: protocol errors take precedence over the address decode
   always_comb begin
      w_ld_data = 32'd0;
      w_ld_resp = 2'b00;
      if (w_ld_unsup) begin
         w_ld_resp = 2'b10;
      end else if (!f_in_range(w_ld_addr)) begin
         w_ld_resp = 2'b11;
      end else begin
         w_ld_data = r_mem[f_index(w_ld_addr)];
      end
   end

   // Read FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_r_state <= R_IDLE;
      else          r_r_state <= w_r_state_nxt;
   end

   // Read channel datapath and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_arready  <= 1'b1;
         r_rvalid   <= 1'b0;
         r_rdata    <= 32'd0;
         r_rresp    <= 2'b00;
         r_rlast    <= 1'b0;
         r_cur_addr <= 32'd0;
         r_ar_len   <= 8'd0;
         r_incr     <= 1'b0;
         r_unsup    <= 1'b0;
         r_beat_cnt <= 8'd0;
         r_lat_cnt  <= 4'd0;
      end else begin
         r_arready <= (w_r_state_nxt == R_IDLE);
         r_rvalid  <= (w_r_state_nxt == R_DATA);
         if (w_ar_take) begin
            r_cur_addr <= i_araddr;
            r_ar_len   <= i_arlen;
            r_incr     <= (i_arburst == 2'b01);
            r_unsup    <= f_unsup(i_arburst, i_arsize);
            r_beat_cnt <= 8'd0;
            r_lat_cnt  <= LAT_INIT;
         end else if ((r_r_state == R_WAIT) && (r_lat_cnt != 4'd0)) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
         end
         if (w_load) begin
            r_cur_addr <= w_ld_addr;
            r_beat_cnt <= w_ld_cnt;
            r_rdata    <= w_ld_data;
            r_rresp    <= w_ld_resp;
            r_rlast    <= (w_ld_cnt == w_ld_len);
         end
      end
   end

   // Write FSM next state; AW and W may arrive in either order
   always_comb begin
      w_w_state_nxt = r_w_state;
      w_aw_take     = i_awvalid && r_awready;
      w_wd_take     = i_wvalid && r_wready;
      w_aw_have     = r_aw_got || w_aw_take;
      w_wd_have     = r_wd_got || w_wd_take;
      w_wr_addr     = r_aw_got ? r_aw_addr : i_awaddr;
      w_wr_data     = r_wd_got ? r_wdata : i_wdata;
      w_wr_strb     = r_wd_got ? r_wstrb : i_wstrb;
      w_commit      = 1'b0;
      w_b_done      = 1'b0;
      case (r_w_state)
         W_IDLE: begin
            if (w_aw_have && w_wd_have) begin
               w_commit      = 1'b1;
               w_w_state_nxt = W_RESP;
            end else begin
               w_w_state_nxt = W_IDLE;
            end
         end
         W_RESP: begin
            if (i_bready) begin
               w_b_done      = 1'b1;
               w_w_state_nxt = W_IDLE;
            end else begin
               w_w_state_nxt = W_RESP;
            end
         end
         default: w_w_state_nxt = W_IDLE;
      endcase
   end

   // Write FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_w_state <= W_IDLE;
      else          r_w_state <= w_w_state_nxt;
   end

   // Write channel captures and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_awready <= 1'b1;
         r_wready  <= 1'b1;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
         r_aw_got  <= 1'b0;
         r_wd_got  <= 1'b0;
         r_aw_addr <= 32'd0;
         r_wdata   <= 32'd0;
         r_wstrb   <= 4'd0;
      end else begin
         r_awready <= (w_w_state_nxt == W_IDLE) && ((r_w_state != W_IDLE) || !w_aw_have);
         r_wready  <= (w_w_state_nxt == W_IDLE) && ((r_w_state != W_IDLE) || !w_wd_have);
         r_bvalid  <= (w_w_state_nxt == W_RESP);
         if (w_commit) r_bresp <= f_in_range(w_wr_addr) ? 2'b00 : 2'b11;
         if (w_b_done) begin
            r_aw_got <= 1'b0;
            r_wd_got <= 1'b0;
         end else begin
            if (w_aw_take) begin
               r_aw_got  <= 1'b1;
               r_aw_addr <= i_awaddr;
            end
            if (w_wd_take) begin
               r_wd_got <= 1'b1;
               r_wdata  <= i_wdata;
               r_wstrb  <= i_wstrb;
            end
         end
      end
   end

   // Byte-lane write; the array itself is never reset, and reset blocks a pending commit
   always_ff @(posedge i_clk) begin
      if (w_commit && i_rst_n && f_in_range(w_wr_addr)) begin
         for (int k = 0; k < 4; k++) begin
            if (w_wr_strb[k]) r_mem[f_index(w_wr_addr)][8*k +: 8] <= w_wr_data[8*k +: 8];
         end
      end
   end

   assign o_arready = r_arready;
   assign o_rvalid  = r_rvalid;
   assign o_rdata   = r_rdata;
   assign o_rresp   = r_rresp;
   assign o_rlast   = r_rlast;
   assign o_awready = r_awready;
   assign o_wready  = r_wready;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_bresp;

endmodule
